// File: rtl/demo_sequencer_pkg.sv
// Shared video-pipeline constants: sequencer state/phase codes and datapath widths.
// Phase output codes are identical to the state encodings, so state drives phase directly.
package demo_sequencer_pkg;
  localparam int CTR_W   = 7;
  localparam int WORD_W  = 2;
  localparam int WORDS   = 4;
  localparam int FRAME_W = 10;

  localparam logic [1:0] ST_MUNCH = 2'b00;
  localparam logic [1:0] ST_GAP   = 2'b01;
  localparam logic [1:0] ST_TEXT  = 2'b10;

  typedef logic [FRAME_W-1:0] frame_cnt_t;
  localparam frame_cnt_t FRAME_ONE = frame_cnt_t'(1);
endpackage

// File: rtl/demo_sequencer_frame_timer.sv
// Counts ticks within the current state; expire fires on the Nth counted tick, load on any exit.
// Counter clears on load so the entering tick is never counted.
module demo_sequencer_frame_timer
  import demo_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       count_i,
  input  logic       force_i,
  input  frame_cnt_t limit_i,
  output logic       expire_o,
  output logic       load_o
);
  frame_cnt_t cnt_q, cnt_d;

  assign expire_o = count_i && (cnt_q == (limit_i - FRAME_ONE));
  assign load_o   = expire_o || force_i;

  always_comb begin
    cnt_d = cnt_q;
    if (load_o) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + FRAME_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/demo_sequencer.sv
// Frame-rate scheduler: MUNCH -> (GAP -> TEXT) x4 -> MUNCH, stepping on counted frame ticks.
// All state updates land the cycle after a frame tick; skip requests wait for the next tick.
module demo_sequencer
  import demo_sequencer_pkg::*;
#(
  parameter int MUNCH_FRAMES = 256,
  parameter int GAP_FRAMES   = 15,
  parameter int TEXT_FRAMES  = 90,
  parameter int STEP_DIV     = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              frame_tick_i,
  input  logic              pause_i,
  input  logic              skip_i,
  output logic [CTR_W-1:0]  munch_counter_o,
  output logic              munch_en_o,
  output logic [WORD_W-1:0] text_sel_o,
  output logic              text_en_o,
  output logic [1:0]        phase_o
);
  localparam frame_cnt_t MUNCH_N   = frame_cnt_t'(MUNCH_FRAMES);
  localparam frame_cnt_t GAP_N     = frame_cnt_t'(GAP_FRAMES);
  localparam frame_cnt_t TEXT_N    = frame_cnt_t'(TEXT_FRAMES);
  localparam logic [3:0] STEP_LAST = 4'(STEP_DIV - 1);

  logic [1:0]        state_q, state_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [3:0]        step_q, step_d;
  logic              skip_q, skip_d;

  logic       counted, skip_fire, expire, load;
  frame_cnt_t limit;

  assign counted   = frame_tick_i && !pause_i;
  // A skip in the tick cycle itself is honoured immediately, paused or not.
  assign skip_fire = frame_tick_i && (skip_q || skip_i);

  always_comb begin
    case (state_q)
      ST_GAP:  limit = GAP_N;
      ST_TEXT: limit = TEXT_N;
      default: limit = MUNCH_N;
    endcase
  end

  demo_sequencer_frame_timer u_frame_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .count_i  (counted),
    .force_i  (skip_fire),
    .limit_i  (limit),
    .expire_o (expire),
    .load_o   (load)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    word_d  = word_q;
    step_d  = step_q;
    skip_d  = skip_q;

    if (frame_tick_i) begin
      skip_d = 1'b0;
    end else if (skip_i) begin
      skip_d = 1'b1;
    end

    if (state_q == ST_MUNCH && counted) begin
      if (step_q == STEP_LAST) begin
        step_d = '0;
        ctr_d  = ctr_q + CTR_W'(1);
      end else begin
        step_d = step_q + 4'd1;
      end
    end

    if (load) begin
      case (state_q)
        ST_MUNCH: begin
          state_d = ST_GAP;
          word_d  = '0;
        end
        ST_GAP: state_d = ST_TEXT;
        ST_TEXT: begin
          if (word_q == WORD_W'(WORDS - 1)) begin
            state_d = ST_MUNCH;
            word_d  = '0;
            step_d  = '0;
          end else begin
            state_d = ST_GAP;
            word_d  = word_q + WORD_W'(1);
          end
        end
        default: state_d = ST_MUNCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_MUNCH;
      ctr_q   <= '0;
      word_q  <= '0;
      step_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      word_q  <= word_d;
      step_q  <= step_d;
      skip_q  <= skip_d;
    end
  end

  assign munch_counter_o = ctr_q;
  assign munch_en_o      = (state_q == ST_MUNCH);
  assign text_en_o       = (state_q == ST_TEXT);
  assign text_sel_o      = word_q;
  assign phase_o         = state_q;
endmodule

// File: doc/demo_sequencer.md
# demo_sequencer

Frame-rate scheduler for the video pipeline. Alternates the munch pattern with the four-word text display, and drives the munch animation counter and text word selector from per-frame ticks. All outputs update only on frame boundaries, so a frame never tears. Sits between the video timing generator (source of `frame_tick`) and the munch and text-sequencer datapaths.

## Interface
- `MUNCH_FRAMES`, 256: frames spent in the munch phase; legal range 1..1023.
- `GAP_FRAMES`, 15: blank frames before each word; legal range 1..1023.
- `TEXT_FRAMES`, 90: frames each word is shown; legal range 1..1023.
- `STEP_DIV`, 1: frames per munch counter increment; legal range 1..15.

- `clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse at vblank start. Pulses are at least 2 cycles apart.
- `pause` in 1: level. While high, frame ticks are ignored.
- `skip` in 1: pulse, any cycle. Ends the current state at the next frame tick.
- `munch_counter` out 7: animation counter fed to munch.
- `munch_en` out 1: munch layer visible.
- `text_sel` out 2: word index fed to text_sequencer.
- `text_en` out 1: text layer visible.
- `phase` out 2: 00 = MUNCH, 01 = GAP, 10 = TEXT; 11 is unused.

## Operation
- Reset values:
  - state MUNCH
  - `munch_counter` = 0, `munch_en` = 1
  - `text_sel` = 0, `text_en` = 0, `phase` = 00
  - frame count 0, step count 0, skip_pending 0
- Counted tick: `frame_tick` && !`pause`.
- MUNCH state:
  - `munch_en` = 1, `text_en` = 0.
  - Each counted tick increments step_cnt.
  - When step_cnt == `STEP_DIV`-1, step_cnt clears and `munch_counter` increments. It wraps 127→0.
  - This increment also applies on the exiting tick.
- GAP state: `munch_en` = 0, `text_en` = 0.
- TEXT state: `text_en` = 1, `munch_en` = 0, `text_sel` = word index.
- State durations:
  - A state lasts exactly N counted ticks, with N = `MUNCH_FRAMES`, `GAP_FRAMES` or `TEXT_FRAMES`.
  - The entering tick is not counted.
  - The state exits on the Nth counted tick after entry.
- Transitions:
  - MUNCH→GAP: word index ← 0.
  - GAP→TEXT.
  - TEXT→GAP when word index < 3; word index increments.
  - TEXT→MUNCH when word index == 3; word index ← 0, step_cnt ← 0.
- `munch_counter` holds through GAP and TEXT and resumes from its held value in MUNCH. It is never cleared except by reset.
- Skip:
  - A `skip` pulse sets skip_pending.
  - At the next `frame_tick` the current state exits exactly as if its count expired, and skip_pending clears.
  - Skip is honoured even while `pause` is high; that tick forces the exit only and does not step `munch_counter`.
  - Skip coinciding with natural expiry causes one transition only.
  - A `skip` arriving in the same cycle as `frame_tick` is applied at that tick.
- Frame count is 10 bits and resets to 0 on every state entry.

## Timing
- `frame_tick` at cycle t: every state and output change is visible at t+1.
- Outputs are registered and never change except at t+1 of a frame tick, or on reset.
- Reset mid-operation: all outputs take their reset values on the cycle after `reset` is sampled high, with no tick required. A pending skip is dropped.
- `pause` is sampled on the tick cycle only.

## Structure
- Shared video package holds:
  - state encodings (MUNCH/GAP/TEXT) and the `phase` codes
  - word count (4) and the munch counter width (7)
- One natural sub-module, `frame_timer`:
  - 10-bit tick counter with `load` (state entry) and `expire` (count == N-1 on a counted tick) outputs
  - instanced once; N is muxed by state

## Test plan
Parameters for scenarios 1–4 and 6: `MUNCH_FRAMES`=4, `GAP_FRAMES`=2, `TEXT_FRAMES`=3, `STEP_DIV`=2.
1. Reset, then 4 ticks → `munch_counter` goes 0,1,1,2 (1 after tick 2, 2 after tick 4). After tick 4: `phase`=01, `munch_en`=0, `text_sel`=0.
2. Continue 20 more ticks:
   - `text_en` is high for 3 ticks at each `text_sel` 0,1,2,3, each preceded by 2 GAP ticks.
   - After tick 24: `phase`=00, `munch_en`=1, `munch_counter` still 2.
   - Tick 26 → `munch_counter`=3.
3. In MUNCH, hold `pause` for 5 ticks → no output change. Release, then 1 tick → step continues from the prior step_cnt.
4. During TEXT with `text_sel`=1, pulse `skip` mid-frame → at the next tick `phase`=01, `text_sel`=2. Skip on the same tick as expiry → single transition.
5. `STEP_DIV`=1, `MUNCH_FRAMES`=200, from reset:
   - after 128 ticks `munch_counter`=0 (wrap)
   - after 200 ticks `munch_counter`=72 and `phase`=01
6. Assert `reset` mid-TEXT → next cycle `phase`=00, `munch_en`=1, `text_en`=0, `text_sel`=0, `munch_counter`=0. A skip pulsed before reset has no effect on the next tick.
